// File: rtl/branch_unit.sv
// Branch resolution unit: decodes MIPS-style conditional branches and
// resolves them one cycle after the request. It also keeps a table of 2-bit
// prediction counters and saturating counts of branches and mispredictions.
module branch_unit #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eval_valid,
  input  logic [5:0]        eval_op,
  input  logic [4:0]        eval_rt,
  input  logic [DATA_W-1:0] eval_a,
  input  logic [DATA_W-1:0] eval_b,
  input  logic [DATA_W-1:0] eval_pc,
  input  logic [15:0]       eval_imm,
  input  logic              eval_pred,
  input  logic [DATA_W-1:0] lk_pc,
  output logic              lk_taken,
  output logic              res_valid,
  output logic              res_branch,
  output logic              res_taken,
  output logic [DATA_W-1:0] res_target,
  output logic              res_link,
  output logic [DATA_W-1:0] res_link_val,
  output logic              res_mispred,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_mis
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic              w_is_branch;
  logic              w_cond;
  logic              w_link;
  logic              w_a_zero;
  logic              w_a_neg;
  logic              w_a_eq_b;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_pc_plus4;
  logic [DATA_W-1:0] w_target;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_ev_idx;
  logic              w_unused_lk;

  logic              r_valid;
  logic              r_branch;
  logic              r_taken;
  logic [DATA_W-1:0] r_target;
  logic              r_link;
  logic [DATA_W-1:0] r_link_val;
  logic              r_mispred;
  logic [IDX_W-1:0]  r_upd_idx;
  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_mis;
  logic [1:0]        r_bht [BHT_DEPTH];

  assign w_a_zero   = (eval_a == '0);
  assign w_a_neg    = eval_a[DATA_W-1];
  assign w_a_eq_b   = (eval_a == eval_b);
  assign w_imm_sext = {{(DATA_W-16){eval_imm[15]}}, eval_imm};
  assign w_pc_plus4 = eval_pc + DATA_W'(4);
  assign w_target   = w_pc_plus4 + (w_imm_sext << 2);
  assign w_ev_idx   = eval_pc[IDX_W+1:2];
  assign w_lk_idx   = lk_pc[IDX_W+1:2];

  // Only the index bits of the lookup address select a table entry.
  assign w_unused_lk = ^{lk_pc[DATA_W-1:IDX_W+2], lk_pc[1:0]};

  // Decode the opcode / rt pair into branch, condition and link flags.
  always_comb begin
    w_is_branch = 1'b0;
    w_cond      = 1'b0;
    w_link      = 1'b0;
    case (eval_op)
      OP_BEQ:  begin w_is_branch = 1'b1; w_cond = w_a_eq_b;              end
      OP_BNE:  begin w_is_branch = 1'b1; w_cond = !w_a_eq_b;             end
      OP_BLEZ: begin w_is_branch = 1'b1; w_cond = w_a_neg || w_a_zero;   end
      OP_BGTZ: begin w_is_branch = 1'b1; w_cond = !w_a_neg && !w_a_zero; end
      OP_REGIMM: begin
        case (eval_rt)
          RT_BLTZ:   begin w_is_branch = 1'b1; w_cond = w_a_neg;  end
          RT_BGEZ:   begin w_is_branch = 1'b1; w_cond = !w_a_neg; end
          RT_BLTZAL: begin w_is_branch = 1'b1; w_cond = w_a_neg;  w_link = 1'b1; end
          RT_BGEZAL: begin w_is_branch = 1'b1; w_cond = !w_a_neg; w_link = 1'b1; end
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  // Result register: loads on every accepted request and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_branch   <= 1'b0;
      r_taken    <= 1'b0;
      r_target   <= '0;
      r_link     <= 1'b0;
      r_link_val <= '0;
      r_mispred  <= 1'b0;
      r_upd_idx  <= '0;
    end else begin
      r_valid <= eval_valid;
      if (eval_valid) begin
        r_branch   <= w_is_branch;
        r_taken    <= w_is_branch && w_cond;
        r_target   <= w_target;
        r_link     <= w_link;
        r_link_val <= w_pc_plus4;
        r_mispred  <= w_is_branch && (w_cond != eval_pred);
        r_upd_idx  <= w_ev_idx;
      end
    end
  end

  // Saturating statistics, counted as the result is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (eval_valid && w_is_branch) begin
      if (r_stat_br != '1) r_stat_br <= r_stat_br + STAT_W'(1);
      if ((w_cond != eval_pred) && (r_stat_mis != '1))
        r_stat_mis <= r_stat_mis + STAT_W'(1);
    end
  end

  // Prediction table: trained at the edge closing the result cycle, so a
  // reset on that edge cancels the update of an in-flight branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (r_valid && r_branch) begin
      if (r_taken) begin
        if (r_bht[r_upd_idx] != 2'b11) r_bht[r_upd_idx] <= r_bht[r_upd_idx] + 2'b01;
      end else begin
        if (r_bht[r_upd_idx] != 2'b00) r_bht[r_upd_idx] <= r_bht[r_upd_idx] - 2'b01;
      end
    end
  end

  // Lookup reads the stored value, so a same-cycle update is not visible.
  assign lk_taken     = r_bht[w_lk_idx][1];
  assign res_valid    = r_valid;
  assign res_branch   = r_branch;
  assign res_taken    = r_taken;
  assign res_target   = r_target;
  assign res_link     = r_link;
  assign res_link_val = r_link_val;
  assign res_mispred  = r_mispred;
  assign stat_br      = r_stat_br;
  assign stat_mis     = r_stat_mis;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  localparam int DW = 32;
  localparam int BD = 16;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          eval_valid;
  logic [5:0]    eval_op;
  logic [4:0]    eval_rt;
  logic [DW-1:0] eval_a, eval_b, eval_pc, lk_pc;
  logic [15:0]   eval_imm;
  logic          eval_pred;
  logic          lk_taken;
  logic          res_valid, res_branch, res_taken, res_link, res_mispred;
  logic [DW-1:0] res_target, res_link_val;
  logic [SW-1:0] stat_br, stat_mis;

  always #5 clk = ~clk;

  branch_unit #(.DATA_W(DW), .BHT_DEPTH(BD), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .eval_valid(eval_valid), .eval_op(eval_op),
    .eval_rt(eval_rt), .eval_a(eval_a), .eval_b(eval_b), .eval_pc(eval_pc),
    .eval_imm(eval_imm), .eval_pred(eval_pred), .lk_pc(lk_pc),
    .lk_taken(lk_taken), .res_valid(res_valid), .res_branch(res_branch),
    .res_taken(res_taken), .res_target(res_target), .res_link(res_link),
    .res_link_val(res_link_val), .res_mispred(res_mispred),
    .stat_br(stat_br), .stat_mis(stat_mis)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // reference model state
  int       m_bht [BD];
  int       m_br, m_mis;
  bit       m_init = 0;
  bit       m_pend;
  int       m_pend_idx;
  bit       m_pend_taken;
  bit       e_valid, e_branch, e_taken, e_link, e_mis;
  bit       e_tgt_known, e_lval_known;
  logic [31:0] e_target, e_lval;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_eval(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bit br, output bit tk, output bit lnk);
    int sa;
    sa  = $signed(a);
    br  = 1; tk = 0; lnk = 0;
    if      (op == 6'd4) tk = (a == b);
    else if (op == 6'd5) tk = (a != b);
    else if (op == 6'd6) tk = (sa <= 0);
    else if (op == 6'd7) tk = (sa > 0);
    else if (op == 6'd1 && rt == 5'd0)  tk = (sa < 0);
    else if (op == 6'd1 && rt == 5'd1)  tk = (sa >= 0);
    else if (op == 6'd1 && rt == 5'd16) begin tk = (sa < 0);  lnk = 1; end
    else if (op == 6'd1 && rt == 5'd17) begin tk = (sa >= 0); lnk = 1; end
    else br = 0;
  endfunction

  task automatic cycle(input bit v, input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [15:0] imm, input bit pred, input logic [31:0] lk,
                       input bit rst);
    bit br, tk, lnk;
    reset = rst; eval_valid = v; eval_op = op; eval_rt = rt; eval_a = a; eval_b = b;
    eval_pc = pc; eval_imm = imm; eval_pred = pred; lk_pc = lk;
    #1;
    if (m_init) check("lk_taken", {31'd0, lk_taken}, (m_bht[lk[5:2]] >= 2) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < BD; i++) m_bht[i] = 1;
      m_br = 0; m_mis = 0; m_pend = 0; m_init = 1;
      e_valid = 0; e_branch = 0; e_taken = 0; e_link = 0; e_mis = 0;
      e_target = 0; e_lval = 0; e_tgt_known = 1; e_lval_known = 1;
    end else begin
      if (m_pend) begin
        if (m_pend_taken) m_bht[m_pend_idx] = (m_bht[m_pend_idx] < 3) ? m_bht[m_pend_idx] + 1 : 3;
        else              m_bht[m_pend_idx] = (m_bht[m_pend_idx] > 0) ? m_bht[m_pend_idx] - 1 : 0;
      end
      m_pend = 0;
      e_valid = v;
      if (v) begin
        model_eval(op, rt, a, b, br, tk, lnk);
        e_branch = br;
        e_taken  = br && tk;
        e_link   = br && lnk;
        e_mis    = br && (tk != pred);
        e_target = pc + 32'd4 + 32'(int'($signed(imm)) * 4);
        e_lval   = pc + 32'd4;
        e_tgt_known  = br;
        e_lval_known = br && lnk;
        if (br) begin
          if (m_br < SMAX) m_br++;
          if (e_mis && m_mis < SMAX) m_mis++;
          m_pend = 1; m_pend_idx = int'(pc[5:2]); m_pend_taken = tk;
        end
      end
    end
    #1;
    check("res_valid",   {31'd0, res_valid},   {31'd0, e_valid});
    check("res_branch",  {31'd0, res_branch},  {31'd0, e_branch});
    check("res_taken",   {31'd0, res_taken},   {31'd0, e_taken});
    check("res_link",    {31'd0, res_link},    {31'd0, e_link});
    check("res_mispred", {31'd0, res_mispred}, {31'd0, e_mis});
    if (e_tgt_known)  check("res_target",   res_target,   e_target);
    if (e_lval_known) check("res_link_val", res_link_val, e_lval);
    check("stat_br",  32'(stat_br),  32'(m_br));
    check("stat_mis", 32'(stat_mis), 32'(m_mis));
  endtask

  task automatic idle(input logic [31:0] lk);
    cycle(0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 0, lk, 0);
  endtask

  initial begin
    logic [5:0]  r_op;
    logic [4:0]  r_rt;
    logic [31:0] r_a, r_b, r_pc, r_lk;
    int sel;

    cycle(0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 0, 32'h40, 1);
    cycle(0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 0, 32'h40, 1);
    check("rst_stat_br", 32'(stat_br), 32'd0);
    check("rst_lk_weak_nt", {31'd0, lk_taken}, 32'd0);

    // BEQ equal, predicted not-taken
    cycle(1, 6'd4, 5'd0, 32'd5, 32'd5, 32'h100, 16'h0003, 0, 32'h0, 0);
    check("beq_target", res_target, 32'h110);
    check("beq_mispred", {31'd0, res_mispred}, 32'd1);
    check("beq_stat_mis", 32'(stat_mis), 32'd1);
    idle(32'h100);

    // signed comparisons
    cycle(1, 6'd6, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h300, 16'h0001, 1, 32'h0, 0);
    check("blez_neg1_taken", {31'd0, res_taken}, 32'd1);
    cycle(1, 6'd7, 5'd0, 32'h8000_0000, 32'd0, 32'h304, 16'h0001, 1, 32'h0, 0);
    check("bgtz_min_nt", {31'd0, res_taken}, 32'd0);

    // BGEZAL not taken still links
    cycle(1, 6'd1, 5'd17, 32'hFFFF_FFFC, 32'd0, 32'h200, 16'h0010, 0, 32'h0, 0);
    check("bgezal_link", {31'd0, res_link}, 32'd1);
    check("bgezal_lval", res_link_val, 32'h204);

    // target wrap-around
    cycle(1, 6'd4, 5'd0, 32'd1, 32'd1, 32'h0, 16'h8000, 1, 32'h0, 0);
    check("wrap_target", res_target, 32'hFFFE_0004);

    // counter training at 0x40
    cycle(0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 0, 32'h40, 1);
    for (int i = 0; i < 3; i++) cycle(1, 6'd4, 5'd0, 7, 7, 32'h40, 16'h0, 0, 32'h40, 0);
    idle(32'h40);
    check("train_lk_taken", {31'd0, lk_taken}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 6'd5, 5'd0, 7, 7, 32'h40, 16'h0, 1, 32'h40, 0);
    idle(32'h40);
    check("untrain_lk_nt", {31'd0, lk_taken}, 32'd0);

    // non-branch opcode
    cycle(1, 6'd0, 5'd0, 1, 2, 32'h80, 16'h4, 1, 32'h0, 0);
    check("nonbr_valid", {31'd0, res_valid}, 32'd1);
    check("nonbr_branch", {31'd0, res_branch}, 32'd0);
    cycle(1, 6'd1, 5'd3, 1, 2, 32'h84, 16'h4, 1, 32'h0, 0);

    // request coincident with reset, then request in flight when reset hits
    cycle(1, 6'd4, 5'd0, 3, 3, 32'h48, 16'h1, 0, 32'h48, 1);
    check("rst_req_dropped", {31'd0, res_valid}, 32'd0);
    cycle(1, 6'd4, 5'd0, 3, 3, 32'h48, 16'h1, 0, 32'h48, 0);
    cycle(0, 6'd0, 5'd0, 0, 0, 0, 16'd0, 0, 32'h48, 1);
    cycle(1, 6'd4, 5'd0, 3, 3, 32'h48, 16'h1, 0, 32'h48, 0);
    idle(32'h48);

    // randomized traffic
    r_pc = 32'h0;
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: r_op = 6'd4; 1: r_op = 6'd5; 2: r_op = 6'd6; 3: r_op = 6'd7;
        4, 5: r_op = 6'd1; 6: r_op = 6'd0; default: r_op = 6'($urandom);
      endcase
      sel = $urandom_range(0, 4);
      case (sel)
        0: r_rt = 5'd0; 1: r_rt = 5'd1; 2: r_rt = 5'd16; 3: r_rt = 5'd17;
        default: r_rt = 5'($urandom);
      endcase
      sel = $urandom_range(0, 3);
      case (sel)
        0: r_a = 32'd0; 1: r_a = 32'h8000_0000 | $urandom; 2: r_a = $urandom_range(0, 3);
        default: r_a = $urandom;
      endcase
      r_b = ($urandom_range(0, 1) == 0) ? r_a : $urandom;
      r_pc = ($urandom_range(0, 2) == 0) ? r_pc : ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      r_lk = ($urandom_range(0, 1) == 0) ? r_pc : $urandom;
      cycle(bit'($urandom_range(0, 3) != 0), r_op, r_rt, r_a, r_b, r_pc,
            16'($urandom), bit'($urandom_range(0, 1)), r_lk,
            bit'($urandom_range(0, 59) == 0));
    end
    idle(32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
